// File: rtl/bin_window_gen.sv
// Streaming KxK binary receptive-field generator: K-1 line buffers plus a KxK shift window, valid/ready on both sides.
// Optional macro WIN_COORD_EN adds out_row/out_col window top-left coordinate ports.
module bin_window_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     pix_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K*K-1:0]           win_out,
`ifdef WIN_COORD_EN
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
`endif
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int KK = K * K;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_OFF  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_OFF  = RW'(K - 1);

    logic [CW-1:0]             r_col;
    logic [RW-1:0]             r_row;
    logic [K-2:0][IMG_W-1:0]   r_line;
    logic [KK-1:0]             r_win;
    logic [KK-1:0]             r_win_out;
    logic                      r_out_valid;
    logic                      r_frame_done;
`ifdef WIN_COORD_EN
    logic [RW-1:0]             r_out_row;
    logic [CW-1:0]             r_out_col;
`endif

    logic                      w_accept;
    logic                      w_win_pos;
    logic                      w_last_col;
    logic                      w_last_row;
    logic [K-1:0]              w_colv;
    logic [KK-1:0]             w_win_nxt;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_last_col = (r_col == COL_LAST);
    assign w_last_row = (r_row == ROW_LAST);
    assign w_win_pos  = (r_row >= ROW_OFF) && (r_col >= COL_OFF);

    // Column entering the window: oldest line buffer feeds the top row, the live pixel the bottom row.
    always_comb begin
        w_colv = '0;
        for (int r = 0; r < K - 1; r++) begin
            w_colv[r] = r_line[K-2-r][r_col];
        end
        w_colv[K-1] = pix_in;
    end

    always_comb begin
        w_win_nxt = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                w_win_nxt[r*K+c] = r_win[r*K+c+1];
            end
            w_win_nxt[r*K+K-1] = w_colv[r];
        end
    end

    // Datapath storage is never cleared; every bit is rewritten before a window is first emitted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_win <= w_win_nxt;
            for (int i = 0; i < K - 1; i++) begin
                r_line[i][r_col] <= (i == 0) ? pix_in : r_line[(i == 0) ? 0 : i-1][r_col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_win_out    <= '0;
            r_frame_done <= 1'b0;
`ifdef WIN_COORD_EN
            r_out_row    <= '0;
            r_out_col    <= '0;
`endif
        end else begin
            r_frame_done <= w_accept && w_last_row && w_last_col;
            if (w_accept) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // A new window overrides a same-edge consume, so no beat is lost or duplicated.
            if (w_accept && w_win_pos) begin
                r_out_valid <= 1'b1;
                r_win_out   <= w_win_nxt;
`ifdef WIN_COORD_EN
                r_out_row   <= r_row - ROW_OFF;
                r_out_col   <= r_col - COL_OFF;
`endif
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign win_out    = r_win_out;
    assign frame_done = r_frame_done;
`ifdef WIN_COORD_EN
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
`endif

endmodule
